hnf_sf_access_ctrl: RTL and testbench
=====================================

HNF_SF_ACCESS_CTRL -- requirements
Module: hnf_sf_access_ctrl

Interface
REQ-001 SHALL take SF_INDEX_WIDTH, default 10, as the snoop filter set index width.
REQ-002 SHALL take SF_WAY_NUM, default 4, as the number of snoop filter ways.
REQ-003 SHALL take SF_TAG_WIDTH, default 20, as the tag field width.
REQ-004 SHALL take SF_PRES_WIDTH, default 8, as the presence vector width; SF_CLINE_WIDTH = SF_TAG_WIDTH+SF_PRES_WIDTH; cline = {tag, presence}.
REQ-005 SHALL take SF_RD_LAT, default 2, as the cycles from sf_rd_en_q high to sf_rd_clines_q valid; legal range 1..3.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-010 req_op  in  1  0=lookup, 1=write.
REQ-011 req_index  in  SF_INDEX_WIDTH  set index.
REQ-012 req_tag  in  SF_TAG_WIDTH  lookup tag.
REQ-013 req_wr_ways  in  SF_WAY_NUM  write way mask.
REQ-014 req_wr_cline  in  SF_CLINE_WIDTH  write data.
REQ-015 resp_valid  out  1  lookup result present.
REQ-016 resp_ready  in  1  result consumed when resp_valid&resp_ready.
REQ-017 resp_hit  out  1  tag hit.
REQ-018 resp_hit_way  out  SF_WAY_NUM  one-hot hit way, 0 on miss.
REQ-019 resp_hit_cline  out  SF_CLINE_WIDTH  hit way content, 0 on miss.
REQ-020 resp_victim_way  out  SF_WAY_NUM  one-hot victim, 0 on hit.
REQ-021 resp_victim_cline  out  SF_CLINE_WIDTH  victim content, 0 on hit.
REQ-022 init_done  out  1  array initialisation finished.
REQ-023 sf_index_q  out  SF_INDEX_WIDTH  SRAM index.
REQ-024 sf_rd_en_q  out  1  SRAM read enable.
REQ-025 sf_wr_ways_q  out  SF_WAY_NUM  SRAM per-way write enable.
REQ-026 sf_wr_cline_q  out  SF_CLINE_WIDTH  SRAM write data, common to all written ways.
REQ-027 sf_rd_clines_q  in  SF_CLINE_WIDTH*SF_WAY_NUM  SRAM read data, way i at bits [i*SF_CLINE_WIDTH +: SF_CLINE_WIDTH].

Function
REQ-028 SHALL implement FSM states INIT, IDLE, RD_WAIT, RESP; all sf_* outputs registered.
REQ-029 INIT: each cycle drive sf_index_q=init counter, sf_wr_ways_q=all ones, sf_wr_cline_q=0, sf_rd_en_q=0; counter 0..2^SF_INDEX_WIDTH-1 then -> IDLE, init_done=1 from the cycle after the last write; init_done never falls except on rst.
REQ-030 req_ready = (state==IDLE); low in INIT, RD_WAIT, RESP.
REQ-031 Write accepted at cycle T: at T+1 sf_index_q=req_index, sf_wr_ways_q=req_wr_ways, sf_wr_cline_q=req_wr_cline for exactly one cycle; stay IDLE; back-to-back writes at full rate; no response.
REQ-032 Lookup accepted at T: at T+1 sf_index_q=req_index, sf_rd_en_q=1 for one cycle, tag captured; RD_WAIT counts SF_RD_LAT cycles; sf_rd_clines_q sampled at T+1+SF_RD_LAT; resp_valid=1 at T+2+SF_RD_LAT; state RESP.
REQ-033 Way valid = OR of its presence field; hit = valid and tag equal; multiple hits: lowest index wins.
REQ-034 On miss, victim = lowest-index invalid way; if all valid, victim = way at round-robin pointer.
REQ-035 Round-robin pointer (log2 SF_WAY_NUM bits, reset 0) increments modulo SF_WAY_NUM only when an all-valid miss response is consumed.
REQ-036 resp_* fields stable while resp_valid=1 and resp_ready=0; on consume resp_valid falls next cycle, state -> IDLE.
REQ-037 Idle cycles: sf_rd_en_q=0, sf_wr_ways_q=0; sf_index_q and sf_wr_cline_q hold.
REQ-038 A write at T+1 followed by a lookup accepted at T+1 to same index SHALL return the written data (SRAM write-before-read ordering by cycle).
REQ-039 req_* ignored when req_ready=0; no request lost or duplicated.

Reset
REQ-040 While rst=1: all outputs 0, state INIT, init counter 0, RR pointer 0, pending lookup discarded.
REQ-041 rst asserted mid-lookup or mid-INIT SHALL restart initialisation from index 0 after release; no resp_valid for the aborted lookup.

Verification
REQ-042 SF_INDEX_WIDTH=4: release rst -> 16 cycles writes index 0..15, ways=all ones, cline=0; init_done=1 next cycle.
REQ-043 Write idx 3 ways=0b0010 cline {tag 0x5,pres 0x01}; lookup idx 3 tag 0x5 -> resp_hit=1, hit_way=0b0010, latency SF_RD_LAT+2.
REQ-044 Lookup idx 3 tag 0x6 -> miss, victim_way=0b0001, victim_cline=0.
REQ-045 All 4 ways valid idx 7, two consecutive misses -> victim 0b0001 then 0b0010.
REQ-046 resp_ready low 5 cycles -> resp stable, req_ready=0, no SRAM access.
REQ-047 rst pulsed one cycle after lookup accept -> no resp_valid, init sweep restarts at index 0.

Source files
------------

// File: rtl/hnf_sf_access_ctrl.sv
// Snoop filter SRAM access controller.
// Sweeps the tag array to zero after reset, then serves single-cycle writes
// and fixed-latency lookups that resolve hit way or victim way.
module hnf_sf_access_ctrl #(
  parameter int unsigned SF_INDEX_WIDTH = 10,
  parameter int unsigned SF_WAY_NUM     = 4,
  parameter int unsigned SF_TAG_WIDTH   = 20,
  parameter int unsigned SF_PRES_WIDTH  = 8,
  parameter int unsigned SF_RD_LAT      = 2,
  localparam int unsigned SF_CLINE_WIDTH = SF_TAG_WIDTH + SF_PRES_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_op,
  input  logic [SF_INDEX_WIDTH-1:0]            req_index,
  input  logic [SF_TAG_WIDTH-1:0]              req_tag,
  input  logic [SF_WAY_NUM-1:0]                req_wr_ways,
  input  logic [SF_CLINE_WIDTH-1:0]            req_wr_cline,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic                                 resp_hit,
  output logic [SF_WAY_NUM-1:0]                resp_hit_way,
  output logic [SF_CLINE_WIDTH-1:0]            resp_hit_cline,
  output logic [SF_WAY_NUM-1:0]                resp_victim_way,
  output logic [SF_CLINE_WIDTH-1:0]            resp_victim_cline,
  output logic                                 init_done,
  output logic [SF_INDEX_WIDTH-1:0]            sf_index_q,
  output logic                                 sf_rd_en_q,
  output logic [SF_WAY_NUM-1:0]                sf_wr_ways_q,
  output logic [SF_CLINE_WIDTH-1:0]            sf_wr_cline_q,
  input  logic [SF_CLINE_WIDTH*SF_WAY_NUM-1:0] sf_rd_clines_q
);

  localparam int unsigned RR_W = (SF_WAY_NUM > 1) ? $clog2(SF_WAY_NUM) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD_WAIT, ST_RESP} state_e;

  state_e                    state_q, state_d;
  logic [SF_INDEX_WIDTH:0]   init_cnt_q, init_cnt_d;
  logic [1:0]                lat_cnt_q, lat_cnt_d;
  logic [SF_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [RR_W-1:0]           rr_q, rr_d;
  logic                      rr_adv_q, rr_adv_d;
  logic                      init_done_q, init_done_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      resp_hit_q, resp_hit_d;
  logic [SF_WAY_NUM-1:0]     resp_hit_way_q, resp_hit_way_d;
  logic [SF_CLINE_WIDTH-1:0] resp_hit_cline_q, resp_hit_cline_d;
  logic [SF_WAY_NUM-1:0]     resp_victim_way_q, resp_victim_way_d;
  logic [SF_CLINE_WIDTH-1:0] resp_victim_cline_q, resp_victim_cline_d;
  logic [SF_INDEX_WIDTH-1:0] sf_index_d;
  logic                      sf_rd_en_d;
  logic [SF_WAY_NUM-1:0]     sf_wr_ways_d;
  logic [SF_CLINE_WIDTH-1:0] sf_wr_cline_d;

  logic [SF_CLINE_WIDTH-1:0] way_cline;
  logic                      hit_c, inv_c;
  logic [SF_WAY_NUM-1:0]     hit_way_c, inv_way_c, rr_way_c;
  logic [SF_CLINE_WIDTH-1:0] hit_cline_c, inv_cline_c, rr_cline_c;

  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = resp_valid_q;
  assign resp_hit          = resp_hit_q;
  assign resp_hit_way      = resp_hit_way_q;
  assign resp_hit_cline    = resp_hit_cline_q;
  assign resp_victim_way   = resp_victim_way_q;
  assign resp_victim_cline = resp_victim_cline_q;
  assign init_done         = init_done_q;

  // Resolve lowest hit way, lowest invalid way and the round-robin way from read data.
  always_comb begin
    way_cline   = '0;
    hit_c       = 1'b0;
    inv_c       = 1'b0;
    hit_way_c   = '0;
    inv_way_c   = '0;
    rr_way_c    = '0;
    hit_cline_c = '0;
    inv_cline_c = '0;
    rr_cline_c  = '0;
    for (int unsigned i = 0; i < SF_WAY_NUM; i++) begin
      way_cline = sf_rd_clines_q[i*SF_CLINE_WIDTH +: SF_CLINE_WIDTH];
      if (|way_cline[SF_PRES_WIDTH-1:0]) begin
        if (!hit_c && (way_cline[SF_CLINE_WIDTH-1 -: SF_TAG_WIDTH] == tag_q)) begin
          hit_c        = 1'b1;
          hit_way_c[i] = 1'b1;
          hit_cline_c  = way_cline;
        end
      end else if (!inv_c) begin
        inv_c        = 1'b1;
        inv_way_c[i] = 1'b1;
        inv_cline_c  = way_cline;
      end
      if (RR_W'(i) == rr_q) begin
        rr_way_c[i] = 1'b1;
        rr_cline_c  = way_cline;
      end
    end
  end

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d             = state_q;
    init_cnt_d          = init_cnt_q;
    lat_cnt_d           = lat_cnt_q;
    tag_d               = tag_q;
    rr_d                = rr_q;
    rr_adv_d            = rr_adv_q;
    init_done_d         = init_done_q;
    resp_valid_d        = resp_valid_q;
    resp_hit_d          = resp_hit_q;
    resp_hit_way_d      = resp_hit_way_q;
    resp_hit_cline_d    = resp_hit_cline_q;
    resp_victim_way_d   = resp_victim_way_q;
    resp_victim_cline_d = resp_victim_cline_q;
    sf_index_d          = sf_index_q;
    sf_wr_cline_d       = sf_wr_cline_q;
    sf_rd_en_d          = 1'b0;
    sf_wr_ways_d        = '0;
    case (state_q)
      ST_INIT: begin
        // Extra counter MSB marks sweep completion so IDLE and init_done rise together.
        if (!init_cnt_q[SF_INDEX_WIDTH]) begin
          sf_index_d    = init_cnt_q[SF_INDEX_WIDTH-1:0];
          sf_wr_ways_d  = '1;
          sf_wr_cline_d = '0;
          init_cnt_d    = init_cnt_q + (SF_INDEX_WIDTH+1)'(1);
        end else begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          sf_index_d = req_index;
          if (req_op) begin
            sf_wr_ways_d  = req_wr_ways;
            sf_wr_cline_d = req_wr_cline;
          end else begin
            sf_rd_en_d = 1'b1;
            tag_d      = req_tag;
            lat_cnt_d  = '0;
            state_d    = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q == 2'(SF_RD_LAT)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_hit_d   = hit_c;
          rr_adv_d     = 1'b0;
          if (hit_c) begin
            resp_hit_way_d      = hit_way_c;
            resp_hit_cline_d    = hit_cline_c;
            resp_victim_way_d   = '0;
            resp_victim_cline_d = '0;
          end else begin
            resp_hit_way_d   = '0;
            resp_hit_cline_d = '0;
            if (inv_c) begin
              resp_victim_way_d   = inv_way_c;
              resp_victim_cline_d = inv_cline_c;
            end else begin
              resp_victim_way_d   = rr_way_c;
              resp_victim_cline_d = rr_cline_c;
              rr_adv_d            = 1'b1;
            end
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
          if (rr_adv_q) begin
            rr_d = (rr_q == RR_W'(SF_WAY_NUM-1)) ? '0 : rr_q + RR_W'(1);
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers; reset restarts the initialisation sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= ST_INIT;
      init_cnt_q          <= '0;
      lat_cnt_q           <= '0;
      tag_q               <= '0;
      rr_q                <= '0;
      rr_adv_q            <= 1'b0;
      init_done_q         <= 1'b0;
      resp_valid_q        <= 1'b0;
      resp_hit_q          <= 1'b0;
      resp_hit_way_q      <= '0;
      resp_hit_cline_q    <= '0;
      resp_victim_way_q   <= '0;
      resp_victim_cline_q <= '0;
      sf_index_q          <= '0;
      sf_rd_en_q          <= 1'b0;
      sf_wr_ways_q        <= '0;
      sf_wr_cline_q       <= '0;
    end else begin
      state_q             <= state_d;
      init_cnt_q          <= init_cnt_d;
      lat_cnt_q           <= lat_cnt_d;
      tag_q               <= tag_d;
      rr_q                <= rr_d;
      rr_adv_q            <= rr_adv_d;
      init_done_q         <= init_done_d;
      resp_valid_q        <= resp_valid_d;
      resp_hit_q          <= resp_hit_d;
      resp_hit_way_q      <= resp_hit_way_d;
      resp_hit_cline_q    <= resp_hit_cline_d;
      resp_victim_way_q   <= resp_victim_way_d;
      resp_victim_cline_q <= resp_victim_cline_d;
      sf_index_q          <= sf_index_d;
      sf_rd_en_q          <= sf_rd_en_d;
      sf_wr_ways_q        <= sf_wr_ways_d;
      sf_wr_cline_q       <= sf_wr_cline_d;
    end
  end

endmodule

// File: tb/tb_hnf_sf_access_ctrl.sv
// Directed bench for hnf_sf_access_ctrl with a behavioural SRAM model.
module tb_hnf_sf_access_ctrl;

  localparam int unsigned IW  = 4;
  localparam int unsigned WN  = 4;
  localparam int unsigned TW  = 20;
  localparam int unsigned PW  = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned CW  = TW + PW;
  localparam int unsigned RW  = 1 + WN + CW + WN + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_op = 1'b0;
  logic [IW-1:0] req_index = '0;
  logic [TW-1:0] req_tag = '0;
  logic [WN-1:0] req_wr_ways = '0;
  logic [CW-1:0] req_wr_cline = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_hit;
  logic [WN-1:0] resp_hit_way;
  logic [CW-1:0] resp_hit_cline;
  logic [WN-1:0] resp_victim_way;
  logic [CW-1:0] resp_victim_cline;
  logic          init_done;
  logic [IW-1:0] sf_index_q;
  logic          sf_rd_en_q;
  logic [WN-1:0] sf_wr_ways_q;
  logic [CW-1:0] sf_wr_cline_q;
  logic [CW*WN-1:0] sf_rd_clines_q;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hnf_sf_access_ctrl #(
    .SF_INDEX_WIDTH(IW),
    .SF_WAY_NUM    (WN),
    .SF_TAG_WIDTH  (TW),
    .SF_PRES_WIDTH (PW),
    .SF_RD_LAT     (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_index        (req_index),
    .req_tag          (req_tag),
    .req_wr_ways      (req_wr_ways),
    .req_wr_cline     (req_wr_cline),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_hit         (resp_hit),
    .resp_hit_way     (resp_hit_way),
    .resp_hit_cline   (resp_hit_cline),
    .resp_victim_way  (resp_victim_way),
    .resp_victim_cline(resp_victim_cline),
    .init_done        (init_done),
    .sf_index_q       (sf_index_q),
    .sf_rd_en_q       (sf_rd_en_q),
    .sf_wr_ways_q     (sf_wr_ways_q),
    .sf_wr_cline_q    (sf_wr_cline_q),
    .sf_rd_clines_q   (sf_rd_clines_q)
  );

  // SRAM model: per-way write enables, read data LAT cycles after the read enable.
  logic [CW-1:0]    mem [0:(1<<IW)-1][0:WN-1];
  logic [CW*WN-1:0] rd_word;
  logic [CW*WN-1:0] rd_pipe [0:LAT-1];

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < WN; w++) rd_word[w*CW +: CW] = mem[sf_index_q][w];
  end

  always @(posedge clk) begin
    for (int w = 0; w < WN; w++)
      if (sf_wr_ways_q[w]) mem[sf_index_q][w] <= sf_wr_cline_q;
    rd_pipe[0] <= sf_rd_en_q ? rd_word : '0;
    for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end

  assign sf_rd_clines_q = rd_pipe[LAT-1];

  logic [RW-1:0] resp_bus;
  assign resp_bus = {resp_hit, resp_hit_way, resp_hit_cline, resp_victim_way, resp_victim_cline};

  function automatic logic [CW-1:0] cl(input logic [TW-1:0] t, input logic [PW-1:0] p);
    return {t, p};
  endfunction

  function automatic logic [RW-1:0] er(input logic h, input logic [WN-1:0] hw, input logic [CW-1:0] hc,
                                       input logic [WN-1:0] vw, input logic [CW-1:0] vc);
    return {h, hw, hc, vw, vc};
  endfunction

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [IW-1:0] idx, input logic [WN-1:0] ways, input logic [CW-1:0] c);
    req_valid = 1'b1; req_op = 1'b1; req_index = idx; req_wr_ways = ways; req_wr_cline = c;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           output int lat, output logic [IW+WN:0] first_sf);
    req_valid = 1'b1; req_op = 1'b0; req_index = idx; req_tag = tag;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    first_sf = {sf_rd_en_q, sf_wr_ways_q, sf_index_q};
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (resp_valid !== 1'b1) lat = 99;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, init_done, sf_rd_en_q} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, resp_valid, init_done, sf_rd_en_q});
    end
    tests_run++;
    if ({sf_index_q, sf_wr_ways_q, sf_wr_cline_q} !== '0) begin
      tests_failed++; $display("FAIL reset_sf: got %h expected 0", {sf_index_q, sf_wr_ways_q, sf_wr_cline_q});
    end
    tests_run++;
    if (resp_bus !== '0) begin
      tests_failed++; $display("FAIL reset_resp: got %h expected 0", resp_bus);
    end
  endtask

  task automatic test_init();
    rst = 1'b0;
    // A request during the sweep must be ignored.
    req_valid = 1'b1; req_op = 1'b1; req_index = 4'h2; req_wr_ways = 4'h3; req_wr_cline = cl(20'hABC, 8'h1);
    for (int k = 0; k < (1 << IW); k++) begin
      @(negedge clk);
      if (k == 8) req_valid = 1'b0;
      tests_run++;
      if ({sf_index_q, sf_wr_ways_q, sf_wr_cline_q, sf_rd_en_q, init_done, req_ready} !==
          {IW'(k), 4'hF, 28'h0, 1'b0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL init_sweep[%0d]: got idx=%h ways=%h cl=%h rd=%b done=%b rdy=%b expected idx=%h ways=f cl=0 rd=0 done=0 rdy=0",
                 k, sf_index_q, sf_wr_ways_q, sf_wr_cline_q, sf_rd_en_q, init_done, req_ready, IW'(k));
      end
    end
    @(negedge clk);
    tests_run++;
    if ({init_done, req_ready, sf_wr_ways_q, sf_index_q} !== {1'b1, 1'b1, 4'h0, 4'hF}) begin
      tests_failed++; $display("FAIL init_done: got %h expected %h", {init_done, req_ready, sf_wr_ways_q, sf_index_q}, {1'b1, 1'b1, 4'h0, 4'hF});
    end
  endtask

  task automatic test_write_hit();
    int lat; logic [IW+WN:0] fs;
    do_write(4'h3, 4'b0010, cl(20'h5, 8'h01));
    tests_run++;
    if ({sf_index_q, sf_wr_ways_q, sf_wr_cline_q, sf_rd_en_q} !== {4'h3, 4'b0010, cl(20'h5, 8'h01), 1'b0}) begin
      tests_failed++; $display("FAIL write_issue: got %h expected %h", {sf_index_q, sf_wr_ways_q, sf_wr_cline_q, sf_rd_en_q}, {4'h3, 4'b0010, cl(20'h5, 8'h01), 1'b0});
    end
    do_lookup(4'h3, 20'h5, lat, fs);
    tests_run++;
    if (fs !== {1'b1, 4'h0, 4'h3}) begin
      tests_failed++; $display("FAIL lookup_issue: got %h expected %h", fs, {1'b1, 4'h0, 4'h3});
    end
    tests_run++;
    if (lat !== LAT + 2) begin
      tests_failed++; $display("FAIL hit_latency: got %0d expected %0d", lat, LAT + 2);
    end
    tests_run++;
    if (resp_bus !== er(1'b1, 4'b0010, cl(20'h5, 8'h01), 4'b0, '0)) begin
      tests_failed++; $display("FAIL hit_resp: got %h expected %h", resp_bus, er(1'b1, 4'b0010, cl(20'h5, 8'h01), 4'b0, '0));
    end
    consume();
    tests_run++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL consume: got %b expected 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_miss();
    int lat; logic [IW+WN:0] fs;
    do_lookup(4'h3, 20'h6, lat, fs);
    tests_run++;
    if ({lat, resp_bus} !== {LAT + 2, er(1'b0, 4'b0, '0, 4'b0001, '0)}) begin
      tests_failed++; $display("FAIL miss_invalid: got lat=%0d %h expected lat=%0d %h", lat, resp_bus, LAT + 2, er(1'b0, 4'b0, '0, 4'b0001, '0));
    end
    consume();
    // Zero tag matches the swept content but presence is empty, so it must miss.
    do_lookup(4'hC, 20'h0, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b0001, '0)) begin
      tests_failed++; $display("FAIL miss_nopres: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b0001, '0));
    end
    consume();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_op = 1'b1; req_index = 4'h7;
      req_wr_ways = WN'(1 << i); req_wr_cline = cl(TW'(20'h100 + i), PW'(1 << i));
      @(posedge clk); @(negedge clk);
      tests_run++;
      if ({sf_index_q, sf_wr_ways_q, sf_wr_cline_q} !== {4'h7, WN'(1 << i), cl(TW'(20'h100 + i), PW'(1 << i))}) begin
        tests_failed++; $display("FAIL b2b_write[%0d]: got %h expected %h", i, {sf_index_q, sf_wr_ways_q, sf_wr_cline_q},
                                 {4'h7, WN'(1 << i), cl(TW'(20'h100 + i), PW'(1 << i))});
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({sf_index_q, sf_wr_ways_q, sf_wr_cline_q, sf_rd_en_q} !== {4'h7, 4'h0, cl(20'h103, 8'h08), 1'b0}) begin
      tests_failed++; $display("FAIL idle_hold: got %h expected %h", {sf_index_q, sf_wr_ways_q, sf_wr_cline_q, sf_rd_en_q}, {4'h7, 4'h0, cl(20'h103, 8'h08), 1'b0});
    end
  endtask

  task automatic test_multi_hit();
    int lat; logic [IW+WN:0] fs;
    do_write(4'h5, 4'b1110, cl(20'h77, 8'h80));
    do_lookup(4'h5, 20'h77, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b1, 4'b0010, cl(20'h77, 8'h80), 4'b0, '0)) begin
      tests_failed++; $display("FAIL multi_hit: got %h expected %h", resp_bus, er(1'b1, 4'b0010, cl(20'h77, 8'h80), 4'b0, '0));
    end
    consume();
    do_write(4'h9, 4'b0011, cl(20'h1, 8'h01));
    do_lookup(4'h9, 20'h2, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b0100, '0)) begin
      tests_failed++; $display("FAIL low_invalid: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b0100, '0));
    end
    consume();
  endtask

  task automatic test_round_robin();
    int lat; logic [IW+WN:0] fs;
    do_lookup(4'h7, 20'h102, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b1, 4'b0100, cl(20'h102, 8'h04), 4'b0, '0)) begin
      tests_failed++; $display("FAIL full_hit: got %h expected %h", resp_bus, er(1'b1, 4'b0100, cl(20'h102, 8'h04), 4'b0, '0));
    end
    consume();
    do_lookup(4'h7, 20'h999, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b0001, cl(20'h100, 8'h01))) begin
      tests_failed++; $display("FAIL rr_first: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b0001, cl(20'h100, 8'h01)));
    end
    consume();
    do_lookup(4'h7, 20'h999, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b0010, cl(20'h101, 8'h02))) begin
      tests_failed++; $display("FAIL rr_second: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b0010, cl(20'h101, 8'h02)));
    end
    consume();
  endtask

  task automatic test_stall();
    int lat; logic [IW+WN:0] fs;
    do_lookup(4'h7, 20'h999, lat, fs);
    req_valid = 1'b1; req_op = 1'b1; req_index = 4'h7; req_wr_ways = 4'hF; req_wr_cline = cl(20'hDEAD, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if ({resp_valid, req_ready, sf_rd_en_q, sf_wr_ways_q, resp_bus} !==
          {1'b1, 1'b0, 1'b0, 4'h0, er(1'b0, 4'b0, '0, 4'b0100, cl(20'h102, 8'h04))}) begin
        tests_failed++; $display("FAIL stall[%0d]: got v=%b rdy=%b rd=%b wr=%h resp=%h expected v=1 rdy=0 rd=0 wr=0 resp=%h",
                                 i, resp_valid, req_ready, sf_rd_en_q, sf_wr_ways_q, resp_bus, er(1'b0, 4'b0, '0, 4'b0100, cl(20'h102, 8'h04)));
      end
    end
    req_valid = 1'b0;
    consume();
    tests_run++;
    if ({resp_valid, req_ready, sf_wr_ways_q} !== {1'b0, 1'b1, 4'h0}) begin
      tests_failed++; $display("FAIL stall_release: got %h expected %h", {resp_valid, req_ready, sf_wr_ways_q}, {1'b0, 1'b1, 4'h0});
    end
    do_lookup(4'h7, 20'h999, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b1000, cl(20'h103, 8'h08))) begin
      tests_failed++; $display("FAIL rr_last: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b1000, cl(20'h103, 8'h08)));
    end
    consume();
    do_lookup(4'h7, 20'h999, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b0001, cl(20'h100, 8'h01))) begin
      tests_failed++; $display("FAIL rr_wrap: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b0001, cl(20'h100, 8'h01)));
    end
    consume();
  endtask

  task automatic test_reset_mid_lookup();
    int lat; logic [IW+WN:0] fs; int bad;
    req_valid = 1'b1; req_op = 1'b0; req_index = 4'h7; req_tag = 20'h999;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (sf_rd_en_q !== 1'b1) begin
      tests_failed++; $display("FAIL abort_accept: got %b expected 1", sf_rd_en_q);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({init_done, sf_rd_en_q, resp_valid, req_ready, sf_index_q} !== '0) begin
      tests_failed++; $display("FAIL async_reset: got %h expected 0", {init_done, sf_rd_en_q, resp_valid, req_ready, sf_index_q});
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < (1 << IW); k++) begin
      @(negedge clk);
      if ({sf_index_q, sf_wr_ways_q, resp_valid} !== {IW'(k), 4'hF, 1'b0}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL resweep: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if ({init_done, resp_valid} !== 2'b10) begin
      tests_failed++; $display("FAIL resweep_done: got %b expected 10", {init_done, resp_valid});
    end
    do_write(4'h2, 4'hF, cl(20'h42, 8'h01));
    do_lookup(4'h2, 20'h43, lat, fs);
    tests_run++;
    if (resp_bus !== er(1'b0, 4'b0, '0, 4'b0001, cl(20'h42, 8'h01))) begin
      tests_failed++; $display("FAIL rr_after_reset: got %h expected %h", resp_bus, er(1'b0, 4'b0, '0, 4'b0001, cl(20'h42, 8'h01)));
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_hit();
    test_miss();
    test_back_to_back();
    test_multi_hit();
    test_round_robin();
    test_stall();
    test_reset_mid_lookup();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
